cn_u: RTL and testbench
=======================

// Module: cn_u
// PURPOSE
//   Check-node update/compress unit: writer side of the compressed CN message store.
//   Consumes one row's v2c (q) messages serially, one column per accepted beat.
//   Per message: emits the sign for the per-position sign memory.
//   Per row: emits min0/min1 magnitudes, min0 column index and total sign.
//   The CN-recover unit later rebuilds c2v (r) messages from exactly these fields.
// PARAMETERS
//   MSG_WIDTH    6   two's-complement v2c width; magnitude width ABS_WID = MSG_WIDTH-1
//   COL_CNT_WID  4   column counter / index width; max row length 2**COL_CNT_WID
// PORTS
//   i_clk            in   1            clock
//   i_rst_n          in   1            synchronous, active-low reset
//   i_v2c            in   MSG_WIDTH    v2c message, two's complement
//   i_v2c_vld        in   1            message valid; accepted every cycle it is high
//   i_row_start      in   1            qualifies first message of a row (with i_v2c_vld)
//   i_row_last       in   1            qualifies last message of a row (with i_v2c_vld)
//   o_sign_vld       out  1            per-message sign write strobe
//   o_v2c_sign       out  1            sign of accepted message
//   o_sign_col       out  COL_CNT_WID  column position of that message within the row
//   o_row_vld        out  1            one-cycle pulse: row results valid
//   o_v2c_abs_0      out  ABS_WID      smallest magnitude in row (min0)
//   o_v2c_abs_1      out  ABS_WID      second-smallest magnitude (min1)
//   o_idx_0          out  COL_CNT_WID  column of min0
//   o_v2c_sign_tot   out  1            XOR of all signs in row
// BEHAVIOUR
// - Reset (i_rst_n=0 at posedge): all outputs 0; accumulators cleared; row state IDLE.
// - Magnitude: abs = |i_v2c|; -2**(MSG_WIDTH-1) saturates to all-ones (2**ABS_WID-1).
//   sign = i_v2c[MSG_WIDTH-1].
// - States: IDLE (no open row), ACC (row open).
//   Beat with vld&start: from any state -> ACC. Counter := 1. min0 := abs; min1 := all-ones;
//   idx0 := 0; sign_tot := sign. Any partial row is abandoned without o_row_vld.
//   Beat with vld & !start in ACC: col = counter. Counter increments and saturates at all-ones.
//   Update rules:
//     abs < min0:            min1 := min0; min0 := abs; idx0 := col
//     else if abs < min1:    min1 := abs
//   sign_tot ^= sign.
//   Comparisons are strict: on ties the earliest column keeps idx0, and the equal value
//   goes into min1.
//   Beat with vld & !start in IDLE: dropped. No sign strobe, no state change.
// - i_row_last on an accepted beat:
//   - Close the row: next cycle o_row_vld=1 for exactly one cycle. Result outputs carry
//     values including that last beat; ACC -> IDLE.
//   - start & last in the same beat: single-column row, min1 = all-ones.
// - Result outputs hold until the next o_row_vld; they do not change during accumulation.
// - Back-to-back rows allowed: new start in the cycle after last; no bubble required.
// - Per-message latency 1: the cycle after each accepted beat, o_sign_vld=1 with
//   o_v2c_sign and o_sign_col (start beat col=0). Otherwise o_sign_vld=0 and the data holds.
// - i_v2c_vld low: no state change (gaps inside a row allowed).
// - Reset mid-row: partial row discarded, no o_row_vld.
// TESTING (MSG_WIDTH=6, COL_CNT_WID=4)
// - Row 5,-3,7,-3 (start on 1st, last on 4th) -> 1 cycle after last beat: o_row_vld=1,
//   abs_0=3, abs_1=3, idx_0=1, sign_tot=0.
// - Same row: o_sign_vld on 4 consecutive cycles; cols 0,1,2,3; signs 0,1,0,1.
// - Single beat -32 with start&last -> abs_0=31, abs_1=31, idx_0=0, sign_tot=1.
// - Row 9,4,2,6 with vld gaps of 2 cycles -> abs_0=2, abs_1=4, idx_0=2, sign_tot=0;
//   results unchanged during gaps.
// - start, 2 beats, then start on row -1,1,8 last -> single o_row_vld: abs_0=1, abs_1=1,
//   idx_0=0, sign_tot=1.
// - Reset asserted after 2 beats of a row -> all outputs 0, no o_row_vld; beats before a
//   new start are dropped.

Source files
------------

// File: rtl/cn_u.sv
// cn_u: check-node update/compress unit (writer side of the compressed CN store).
// Consumes one row of v2c messages serially, one column per accepted beat.
// Ports:
//   i_clk, i_rst_n       clock, synchronous active-low reset
//   i_v2c                v2c message, two's complement, MSG_WIDTH bits
//   i_v2c_vld            message valid, accepted every cycle it is high
//   i_row_start          qualifies first message of a row
//   i_row_last           qualifies last message of a row
//   o_sign_vld           per-message sign write strobe (1 cycle after the beat)
//   o_v2c_sign           sign of the accepted message
//   o_sign_col           column of that message within the row
//   o_row_vld            one-cycle pulse: row results valid
//   o_v2c_abs_0/_1       smallest / second-smallest magnitude in the row
//   o_idx_0              column of the smallest magnitude
//   o_v2c_sign_tot       XOR of all signs in the row
module cn_u #(
  parameter int MSG_WIDTH   = 6,
  parameter int COL_CNT_WID = 4,
  localparam int ABS_WID    = MSG_WIDTH - 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [MSG_WIDTH-1:0]   i_v2c,
  input  logic                   i_v2c_vld,
  input  logic                   i_row_start,
  input  logic                   i_row_last,
  output logic                   o_sign_vld,
  output logic                   o_v2c_sign,
  output logic [COL_CNT_WID-1:0] o_sign_col,
  output logic                   o_row_vld,
  output logic [ABS_WID-1:0]     o_v2c_abs_0,
  output logic [ABS_WID-1:0]     o_v2c_abs_1,
  output logic [COL_CNT_WID-1:0] o_idx_0,
  output logic                   o_v2c_sign_tot
);

  typedef enum logic {IDLE, ACC} state_t;

  state_t state_q, state_d;

  logic [COL_CNT_WID-1:0] cnt_q, cnt_d;
  logic [ABS_WID-1:0]     min0_q, min0_d, min1_q, min1_d;
  logic [COL_CNT_WID-1:0] idx_q, idx_d;
  logic                   stot_q, stot_d;

  logic                   sign;
  logic [ABS_WID-1:0]     abs_v, neg_low;
  logic                   accept, close;
  logic [COL_CNT_WID-1:0] col;

  // Magnitude; the most negative code has no positive twin and saturates.
  always_comb begin
    sign    = i_v2c[MSG_WIDTH-1];
    neg_low = ~i_v2c[ABS_WID-1:0] + 1'b1;
    if (!sign)                        abs_v = i_v2c[ABS_WID-1:0];
    else if (i_v2c[ABS_WID-1:0] == '0) abs_v = '1;
    else                              abs_v = neg_low;
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state: a start beat opens a row from any state; a last beat closes it.
  always_comb begin
    state_d = state_q;
    accept  = i_v2c_vld && (i_row_start || (state_q == ACC));
    if (accept) state_d = i_row_last ? IDLE : ACC;
  end

  // Accumulator next values for the current beat
  always_comb begin
    close  = accept && i_row_last;
    col    = i_row_start ? '0 : cnt_q;
    cnt_d  = cnt_q;
    min0_d = min0_q;
    min1_d = min1_q;
    idx_d  = idx_q;
    stot_d = stot_q;
    if (i_row_start) begin
      cnt_d  = {{(COL_CNT_WID-1){1'b0}}, 1'b1};
      min0_d = abs_v;
      min1_d = '1;
      idx_d  = '0;
      stot_d = sign;
    end else begin
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      if (abs_v < min0_q) begin
        min1_d = min0_q;
        min0_d = abs_v;
        idx_d  = col;
      end else if (abs_v < min1_q) begin
        min1_d = abs_v;
      end
      stot_d = stot_q ^ sign;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q          <= '0;
      min0_q         <= '0;
      min1_q         <= '0;
      idx_q          <= '0;
      stot_q         <= 1'b0;
      o_sign_vld     <= 1'b0;
      o_v2c_sign     <= 1'b0;
      o_sign_col     <= '0;
      o_row_vld      <= 1'b0;
      o_v2c_abs_0    <= '0;
      o_v2c_abs_1    <= '0;
      o_idx_0        <= '0;
      o_v2c_sign_tot <= 1'b0;
    end else begin
      o_sign_vld <= accept;
      o_row_vld  <= close;
      if (accept) begin
        cnt_q      <= cnt_d;
        min0_q     <= min0_d;
        min1_q     <= min1_d;
        idx_q      <= idx_d;
        stot_q     <= stot_d;
        o_v2c_sign <= sign;
        o_sign_col <= col;
      end
      // Results are published straight from the next values so the last beat is included.
      if (close) begin
        o_v2c_abs_0    <= min0_d;
        o_v2c_abs_1    <= min1_d;
        o_idx_0        <= idx_d;
        o_v2c_sign_tot <= stot_d;
      end
    end
  end

endmodule

// File: tb/tb_cn_u.sv
module tb_cn_u;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] v2c;
  logic       vld, start, last;
  logic       sign_vld, v2c_sign, row_vld, sign_tot;
  logic [3:0] sign_col, idx_0;
  logic [4:0] abs_0, abs_1;

  int n_chk = 0;
  int n_bad = 0;

  logic [15:0] row_o;
  logic [5:0]  sgn_o;
  assign row_o = {row_vld, abs_0, abs_1, idx_0, sign_tot};
  assign sgn_o = {sign_vld, v2c_sign, sign_col};

  cn_u #(.MSG_WIDTH(6), .COL_CNT_WID(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_v2c(v2c), .i_v2c_vld(vld),
    .i_row_start(start), .i_row_last(last),
    .o_sign_vld(sign_vld), .o_v2c_sign(v2c_sign), .o_sign_col(sign_col),
    .o_row_vld(row_vld), .o_v2c_abs_0(abs_0), .o_v2c_abs_1(abs_1),
    .o_idx_0(idx_0), .o_v2c_sign_tot(sign_tot)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input int v, input logic vl, input logic st, input logic ls);
    v2c = 6'(v); vld = vl; start = st; last = ls;
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] rw(input logic rv, input int a0, input int a1,
                                     input int ix, input logic s);
    return {rv, 5'(a0), 5'(a1), 4'(ix), s};
  endfunction

  function automatic logic [5:0] sg(input logic sv, input logic s, input int c);
    return {sv, s, 4'(c)};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    step(0, 0, 0, 0);
    step(-7, 1, 1, 1);
    if (row_o !== 16'd0) begin $display("FAIL reset_row got=%h exp=0000", row_o); n_bad++; end
    n_chk++;
    if (sgn_o !== 6'd0) begin $display("FAIL reset_sign got=%h exp=00", sgn_o); n_bad++; end
    n_chk++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic_row;
    int vals[4] = '{5, -3, 7, -3};
    logic sgns[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      step(vals[i], 1, i == 0, i == 3);
      if (sgn_o !== sg(1, sgns[i], i)) begin
        $display("FAIL basic_sign%0d got=%h exp=%h", i, sgn_o, sg(1, sgns[i], i)); n_bad++;
      end
      n_chk++;
      if (i < 3 && row_vld !== 1'b0) begin $display("FAIL basic_early_row%0d got=1 exp=0", i); n_bad++; end
      if (i < 3) n_chk++;
    end
    if (row_o !== rw(1, 3, 3, 1, 0)) begin
      $display("FAIL basic_row got=%h exp=%h", row_o, rw(1, 3, 3, 1, 0)); n_bad++;
    end
    n_chk++;
    step(0, 0, 0, 0);
    if ({row_o, sgn_o} !== {rw(0, 3, 3, 1, 0), sg(0, 1, 3)}) begin
      $display("FAIL basic_hold got=%h exp=%h", {row_o, sgn_o}, {rw(0, 3, 3, 1, 0), sg(0, 1, 3)}); n_bad++;
    end
    n_chk++;
  endtask

  task automatic test_single_neg;
    step(-32, 1, 1, 1);
    if ({row_o, sgn_o} !== {rw(1, 31, 31, 0, 1), sg(1, 1, 0)}) begin
      $display("FAIL single_row got=%h exp=%h", {row_o, sgn_o}, {rw(1, 31, 31, 0, 1), sg(1, 1, 0)}); n_bad++;
    end
    n_chk++;
    step(0, 0, 0, 0);
    if (row_o !== rw(0, 31, 31, 0, 1)) begin
      $display("FAIL single_pulse got=%h exp=%h", row_o, rw(0, 31, 31, 0, 1)); n_bad++;
    end
    n_chk++;
  endtask

  task automatic test_gaps;
    int vals[4] = '{9, 4, 2, 6};
    for (int i = 0; i < 4; i++) begin
      step(vals[i], 1, i == 0, i == 3);
      if (sgn_o !== sg(1, 0, i)) begin
        $display("FAIL gaps_sign%0d got=%h exp=%h", i, sgn_o, sg(1, 0, i)); n_bad++;
      end
      n_chk++;
      if (i == 3) break;
      for (int g = 0; g < 2; g++) begin
        step(vals[i] + 1, 0, 0, 0);
        if ({row_o, sign_vld} !== {rw(0, 31, 31, 0, 1), 1'b0}) begin
          $display("FAIL gaps_hold%0d_%0d got=%h exp=%h", i, g, {row_o, sign_vld},
                   {rw(0, 31, 31, 0, 1), 1'b0}); n_bad++;
        end
        n_chk++;
      end
    end
    if (row_o !== rw(1, 2, 4, 2, 0)) begin
      $display("FAIL gaps_row got=%h exp=%h", row_o, rw(1, 2, 4, 2, 0)); n_bad++;
    end
    n_chk++;
  endtask

  task automatic test_restart;
    int  vals[5] = '{3, 2, -1, 1, 8};
    logic st[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    int  cols[5] = '{0, 1, 0, 1, 2};
    for (int i = 0; i < 5; i++) begin
      step(vals[i], 1, st[i], i == 4);
      if (sgn_o !== sg(1, vals[i] < 0, cols[i])) begin
        $display("FAIL restart_sign%0d got=%h exp=%h", i, sgn_o, sg(1, vals[i] < 0, cols[i])); n_bad++;
      end
      n_chk++;
      if (i < 4) begin
        if (row_o !== rw(0, 2, 4, 2, 0)) begin
          $display("FAIL restart_hold%0d got=%h exp=%h", i, row_o, rw(0, 2, 4, 2, 0)); n_bad++;
        end
        n_chk++;
      end
    end
    if (row_o !== rw(1, 1, 1, 0, 1)) begin
      $display("FAIL restart_row got=%h exp=%h", row_o, rw(1, 1, 1, 0, 1)); n_bad++;
    end
    n_chk++;
  endtask

  task automatic test_back_to_back;
    step(3, 1, 1, 0);
    step(10, 1, 0, 1);
    if (row_o !== rw(1, 3, 10, 0, 0)) begin
      $display("FAIL b2b_row_a got=%h exp=%h", row_o, rw(1, 3, 10, 0, 0)); n_bad++;
    end
    n_chk++;
    step(7, 1, 1, 0);
    if ({row_o, sgn_o} !== {rw(0, 3, 10, 0, 0), sg(1, 0, 0)}) begin
      $display("FAIL b2b_start got=%h exp=%h", {row_o, sgn_o}, {rw(0, 3, 10, 0, 0), sg(1, 0, 0)}); n_bad++;
    end
    n_chk++;
    step(-2, 1, 0, 1);
    if ({row_o, sgn_o} !== {rw(1, 2, 7, 1, 1), sg(1, 1, 1)}) begin
      $display("FAIL b2b_row_b got=%h exp=%h", {row_o, sgn_o}, {rw(1, 2, 7, 1, 1), sg(1, 1, 1)}); n_bad++;
    end
    n_chk++;
  endtask

  task automatic test_idle_drop;
    step(4, 1, 0, 1);
    step(-4, 1, 0, 0);
    if ({row_o, sgn_o} !== {rw(0, 2, 7, 1, 1), sg(0, 1, 1)}) begin
      $display("FAIL idle_drop got=%h exp=%h", {row_o, sgn_o}, {rw(0, 2, 7, 1, 1), sg(0, 1, 1)}); n_bad++;
    end
    n_chk++;
  endtask

  task automatic test_long_row;
    // 16 beats fill columns 0..15; the 17th reuses the saturated column 15.
    for (int i = 0; i < 16; i++) begin
      step(20, 1, i == 0, 0);
      if (sign_col !== 4'(i)) begin $display("FAIL long_col%0d got=%0d exp=%0d", i, sign_col, i); n_bad++; end
      n_chk++;
    end
    step(1, 1, 0, 1);
    if ({row_o, sgn_o} !== {rw(1, 1, 20, 15, 0), sg(1, 0, 15)}) begin
      $display("FAIL long_row got=%h exp=%h", {row_o, sgn_o}, {rw(1, 1, 20, 15, 0), sg(1, 0, 15)}); n_bad++;
    end
    n_chk++;
  endtask

  task automatic test_reset_mid_row;
    step(6, 1, 1, 0);
    step(-5, 1, 0, 0);
    rst_n = 1'b0;
    step(3, 1, 0, 1);
    rst_n = 1'b1;
    if ({row_o, sgn_o} !== 22'd0) begin
      $display("FAIL rstmid_zero got=%h exp=0", {row_o, sgn_o}); n_bad++;
    end
    n_chk++;
    step(2, 1, 0, 1);
    step(0, 0, 0, 0);
    if ({row_o, sgn_o} !== 22'd0) begin
      $display("FAIL rstmid_drop got=%h exp=0", {row_o, sgn_o}); n_bad++;
    end
    n_chk++;
    step(5, 1, 1, 1);
    if (row_o !== rw(1, 5, 31, 0, 0)) begin
      $display("FAIL rstmid_new got=%h exp=%h", row_o, rw(1, 5, 31, 0, 0)); n_bad++;
    end
    n_chk++;
  endtask

  initial begin
    rst_n = 1'b0; v2c = '0; vld = 1'b0; start = 1'b0; last = 1'b0;
    test_reset;
    test_basic_row;
    test_single_neg;
    test_gaps;
    test_restart;
    test_back_to_back;
    test_idle_drop;
    test_long_row;
    test_reset_mid_row;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
